pdp8_banked_mem_ctrl: RTL and testbench
=======================================

// Module: pdp8_banked_mem_ctrl
// PURPOSE
//  Clocked, multi-port, multi-field PDP-8 main-memory controller; successor to the combinational single-port controller.
//  Arbitrates NUM_PORTS requesters (port 0 = CPU, others = DMA/IO) onto one NUM_FIELDS x 4K word array.
//  Adds req/ack handshake, configurable access latency, extended-memory fields and hardware auto-index (0010-0017).
// PARAMETERS
//  WORD_W      12  data word width (bits)
//  ADDR_W      12  in-field address width; field size = 2**ADDR_W words
//  NUM_FIELDS  8   memory fields (extended memory); FIELD_W = $clog2(NUM_FIELDS), min 1
//  NUM_PORTS   2   requester ports; index 0 = CPU, highest priority on reset
//  ACCESS_LAT  2   array access cycles, grant to ack (>=1)
// PORTS
//  clk         in   1                     system clock, all state on posedge
//  reset_n     in   1                     asynchronous, active-low reset
//  req         in   NUM_PORTS             request per port; hold high until ack
//  we          in   NUM_PORTS             1 = write, 0 = read (per port)
//  read_type   in   NUM_PORTS x 2         mem_read_t per port: INSTR_FETCH, DATA_READ, AUTO_INDEX
//  field       in   NUM_PORTS x FIELD_W   field select per port
//  address     in   NUM_PORTS x ADDR_W    in-field address per port
//  write_data  in   NUM_PORTS x WORD_W    write word per port
//  ack         out  NUM_PORTS             one-cycle completion pulse to owning port
//  read_data   out  WORD_W                read result; valid only in ack cycle
//  busy        out  1                     high from grant through ack cycle
// BEHAVIOUR
//  Reset (async assert, sync release): ack=0, read_data=0, busy=0, FSM=IDLE, rr_ptr=0, lat_cnt=0. Array not cleared.
//  FSM IDLE: any req -> latch winner's we/type/field/addr/data, busy=1, -> ACCESS. No req -> stay IDLE.
//  Arbitration: round-robin from rr_ptr; after a grant, rr_ptr = winner+1 (mod NUM_PORTS).
//  ACCESS: lat_cnt counts 0..ACCESS_LAT-1; at last count:
//   write -> mem[f][a]=wdata; read -> read_data=mem[f][a];
//   AUTO_INDEX read with a in 0010..0017 -> mem[f][a]=mem[f][a]+1 (mod 2**WORD_W), read_data=incremented value;
//   AUTO_INDEX outside 0010..0017 behaves as DATA_READ; INSTR_FETCH identical to DATA_READ in data path.
//   -> RESP.
//  RESP: ack[winner]=1 for exactly one cycle, read_data held; busy=1; -> IDLE (busy=0 next cycle).
//  Latency: req seen in IDLE cycle N -> ack in cycle N+ACCESS_LAT+1. Back-to-back: next grant earliest cycle after RESP.
//  Inputs sampled only at grant; changes to a port's inputs after grant do not affect the access.
//  Requester dropping req before ack: access still completes; ack still pulses (port ignores).
//  Writes with we=1 ignore read_type; read_data after write ack = 0.
//  Field index >= NUM_FIELDS: access suppressed (no write), read_data=0, ack still given.
//  Address wrap: none internally; address fully decoded within field; auto-index 7777 -> 0000.
//  Reset mid-ACCESS: pending write not committed, no ack, FSM IDLE, rr_ptr=0.
//  Simultaneous req on all ports: served one per transaction in round-robin order; none starved.
// STRUCTURE
//  Shared package pdp8_mem_pkg: typedef word (logic [11:0]), typedef enum logic [1:0] mem_read_t
//   {INSTR_FETCH, DATA_READ, AUTO_INDEX}, constants AUTOIDX_LO=12'o0010, AUTOIDX_HI=12'o0017,
//   mem_state_t {IDLE, ACCESS, RESP}.
//  One sub-module: pdp8_rr_arbiter (NUM_PORTS req vector + rr_ptr -> one-hot grant, winner index).
//  Array: single reg [WORD_W-1:0] mem [NUM_FIELDS*2**ADDR_W], index {field,address}.
// TESTING
//  1. Reset, port0 write f0 0200=0333, then read f0 0200 -> read_data=0333 at ack, ack 3 cycles after req (LAT=2).
//  2. Write f0 0400=1111, f3 0400=2222; read both -> 1111 and 2222 (fields isolated).
//  3. f0 0010=7777; AUTO_INDEX read 0010 -> 0000, memory 0010=0000; AUTO_INDEX 0020=0005 -> 0005, unchanged.
//  4. Ports 0 and 1 req together, held -> acks port0 then port1, then port0 again; busy gap of one cycle between.
//  5. Assert reset_n=0 during ACCESS of write 0300=4444 -> no ack, outputs 0; later read 0300 returns old value.
//  6. Sweep f0 0000..7777 write data=addr, read back -> every read_data equals address.

Source files
------------

// File: rtl/pdp8_mem_pkg.sv
// Shared types and constants for the banked PDP-8 memory controller.
//   word        : one 12-bit PDP-8 memory word
//   mem_read_t  : read flavour requested by a port
//   mem_state_t : controller FSM states
//   AUTOIDX_LO/HI : in-field auto-index window (0010..0017 octal)
package pdp8_mem_pkg;

    typedef logic [11:0] word;

    typedef enum logic [1:0] {
        INSTR_FETCH = 2'd0,
        DATA_READ   = 2'd1,
        AUTO_INDEX  = 2'd2
    } mem_read_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_t;

    localparam word AUTOIDX_LO = 12'o0010;
    localparam word AUTOIDX_HI = 12'o0017;

endpackage

// File: rtl/pdp8_rr_arbiter.sv
// Round-robin arbiter. The search for a requester starts at rr_ptr_i and
// wraps around, so the port at the pointer has top priority this round.
//   req_i    : request vector, one bit per port
//   rr_ptr_i : port index that gets first look
//   grant_o  : one-hot grant (all zero when nobody requests)
//   winner_o : index of the granted port
//   any_o    : at least one request present
module pdp8_rr_arbiter
    import pdp8_mem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PTR_W-1:0]     rr_ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [PTR_W-1:0]     winner_o,
    output logic                 any_o
);

    int   idx;
    logic found;

    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(rr_ptr_i) + i) % NUM_PORTS;
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                grant_o[idx]  = 1'b1;
                winner_o      = PTR_W'(idx);
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/pdp8_banked_mem_ctrl.sv
// Clocked multi-port, multi-field PDP-8 main-memory controller.
// Requesters raise req and hold it until ack; one access runs at a time.
//   clk, reset_n   : clock, asynchronous active-low reset
//   req/we         : per-port request and write flag
//   read_type      : per-port 2-bit mem_read_t (fetch / data / auto-index)
//   field/address  : per-port field select and in-field address
//   write_data     : per-port write word
//   ack            : one-cycle completion pulse to the owning port
//   read_data      : access result, valid in the ack cycle
//   busy           : high from grant through the ack cycle
module pdp8_banked_mem_ctrl
    import pdp8_mem_pkg::*;
#(
    parameter int  WORD_W     = 12,
    parameter int  ADDR_W     = 12,
    parameter int  NUM_FIELDS = 8,
    parameter int  NUM_PORTS  = 2,
    parameter int  ACCESS_LAT = 2,
    localparam int FIELD_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS*2-1:0]        read_type,
    input  logic [NUM_PORTS*FIELD_W-1:0]  field,
    input  logic [NUM_PORTS*ADDR_W-1:0]   address,
    input  logic [NUM_PORTS*WORD_W-1:0]   write_data,
    output logic [NUM_PORTS-1:0]          ack,
    output logic [WORD_W-1:0]             read_data,
    output logic                          busy
);

    localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LAT_W     = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
    localparam int MEM_AW    = FIELD_W + ADDR_W;
    localparam int MEM_DEPTH = NUM_FIELDS * (2 ** ADDR_W);

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    // Control state (reset)
    mem_state_t           state_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [LAT_W-1:0]     lat_cnt_q;
    logic [NUM_PORTS-1:0] owner_q;
    logic [NUM_PORTS-1:0] ack_q;
    logic                 busy_q;
    logic [WORD_W-1:0]    read_data_q;

    // Request captured at grant (not reset; only meaningful while busy)
    logic                 we_q;
    mem_read_t            type_q;
    logic [FIELD_W-1:0]   field_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [WORD_W-1:0]    wdata_q;

    logic [NUM_PORTS-1:0] grant;
    logic [PTR_W-1:0]     winner;
    logic                 any_req;

    logic                 last_cnt;
    logic                 field_ok;
    logic                 autoinc;
    logic [MEM_AW-1:0]    mem_idx;
    logic [WORD_W-1:0]    rd_raw;
    logic [WORD_W-1:0]    rd_inc;
    logic [WORD_W-1:0]    result_d;
    logic                 mem_we_d;
    logic [WORD_W-1:0]    mem_wdata_d;
    logic [PTR_W-1:0]     rr_ptr_d;

    pdp8_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_arb (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (grant),
        .winner_o (winner),
        .any_o    (any_req)
    );

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign read_data = read_data_q;

    assign rr_ptr_d = PTR_W'((int'(winner) + 1) % NUM_PORTS);

    assign last_cnt = (state_q == ACCESS) && (lat_cnt_q == LAT_W'(ACCESS_LAT - 1));

    // With a power-of-two field count every encodable field exists.
    generate
        if (NUM_FIELDS == (2 ** FIELD_W)) begin : g_field_full
            assign field_ok = 1'b1;
        end else begin : g_field_part
            assign field_ok = (int'(field_q) < NUM_FIELDS);
        end
    endgenerate

    // Auto-index applies only to reads inside the 0010..0017 window;
    // a write ignores read_type entirely.
    assign autoinc = !we_q && (type_q == AUTO_INDEX) &&
                     (addr_q >= ADDR_W'(AUTOIDX_LO)) &&
                     (addr_q <= ADDR_W'(AUTOIDX_HI));

    assign mem_idx = {field_q, addr_q};
    assign rd_raw  = field_ok ? mem[mem_idx] : '0;
    assign rd_inc  = rd_raw + WORD_W'(1);

    always_comb begin
        result_d = '0;
        if (field_ok && !we_q) begin
            result_d = autoinc ? rd_inc : rd_raw;
        end
    end

    // reset_n gates the commit so a write caught by reset never lands.
    assign mem_we_d    = reset_n && last_cnt && field_ok && (we_q || autoinc);
    assign mem_wdata_d = we_q ? wdata_q : rd_inc;

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[mem_idx] <= mem_wdata_d;
        end
    end

    // Inputs are sampled only at grant; later changes are ignored.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && any_req) begin
            we_q    <= we[winner];
            type_q  <= mem_read_t'(read_type[int'(winner)*2 +: 2]);
            field_q <= field[int'(winner)*FIELD_W +: FIELD_W];
            addr_q  <= address[int'(winner)*ADDR_W +: ADDR_W];
            wdata_q <= write_data[int'(winner)*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lat_cnt_q   <= '0;
            owner_q     <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            read_data_q <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q   <= ACCESS;
                        busy_q    <= 1'b1;
                        lat_cnt_q <= '0;
                        owner_q   <= grant;
                        rr_ptr_q  <= rr_ptr_d;
                    end
                end
                ACCESS: begin
                    if (last_cnt) begin
                        state_q     <= RESP;
                        lat_cnt_q   <= '0;
                        read_data_q <= result_d;
                        // ack is registered, so raise it on entry to RESP
                        ack_q       <= owner_q;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdp8_banked_mem_ctrl.sv
module tb_pdp8_banked_mem_ctrl;
    import pdp8_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req, we, ack;
    logic [3:0]  read_type;
    logic [5:0]  field;
    logic [23:0] address, write_data;
    logic [11:0] read_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference memory: contents plus a written flag per location.
    logic [11:0] mdl   [8*4096];
    bit          mvalid[8*4096];

    typedef struct {
        int          port;
        logic        w;
        logic [1:0]  t;
        logic [2:0]  f;
        logic [11:0] a;
        logic [11:0] d;
        logic [11:0] exp;
    } vec_t;

    vec_t vt[16];

    pdp8_banked_mem_ctrl #(
        .WORD_W(12), .ADDR_W(12), .NUM_FIELDS(8), .NUM_PORTS(2), .ACCESS_LAT(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .we         (we),
        .read_type  (read_type),
        .field      (field),
        .address    (address),
        .write_data (write_data),
        .ack        (ack),
        .read_data  (read_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0o want %0o", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word-level behaviour of one access, independent of timing.
    task automatic mdl_apply(input logic w, input logic [1:0] t, input logic [2:0] f,
                             input logic [11:0] a, input logic [11:0] d,
                             output logic [11:0] e);
        int i;
        i = int'(f) * 4096 + int'(a);
        if (w) begin
            mdl[i]    = d;
            mvalid[i] = 1'b1;
            e         = 12'o0;
        end else if (t == AUTO_INDEX && a >= 12'o0010 && a <= 12'o0017) begin
            mdl[i] = mdl[i] + 12'o1;
            e      = mdl[i];
        end else begin
            e = mdl[i];
        end
    endtask

    // One complete transaction on port p, started in an IDLE cycle.
    task automatic do_txn(input int p, input logic w, input logic [1:0] t,
                          input logic [2:0] f, input logic [11:0] a, input logic [11:0] d,
                          input bit scramble, input bit drop_early,
                          output logic [11:0] rd);
        int n;
        bit seen;
        req[p]                = 1'b1;
        we[p]                 = w;
        read_type[p*2 +: 2]   = t;
        field[p*3 +: 3]       = f;
        address[p*12 +: 12]   = a;
        write_data[p*12 +: 12] = d;
        n    = 0;
        seen = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (n == 1) begin
                chk("busy_after_grant", {31'd0, busy}, 32'd1);
                if (scramble) begin
                    address[p*12 +: 12]    = 12'($urandom);
                    write_data[p*12 +: 12] = 12'($urandom);
                    field[p*3 +: 3]        = 3'($urandom);
                    we[p]                  = ~w;
                end
                if (drop_early) req[p] = 1'b0;
            end
            if (ack[p]) seen = 1;
        end
        chk("ack_latency", n, 3);
        chk("ack_onehot", {30'd0, ack}, 32'd1 << p);
        rd     = read_data;
        req[p] = 1'b0;
        tick();
        chk("ack_pulse_end", {30'd0, ack}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [11:0] rd, e;
        logic [11:0] tmp_a, tmp_d;
        logic        rw;
        logic [1:0]  rt;
        logic [2:0]  rf;
        int          rp;

        reset_n = 1'b0;
        req = '0; we = '0; read_type = '0; field = '0; address = '0; write_data = '0;
        for (int i = 0; i < 8*4096; i++) begin
            mdl[i]    = '0;
            mvalid[i] = 1'b0;
        end

        // Directed vector table
        vt[0]  = '{0, 1'b1, DATA_READ,   3'd0, 12'o0200, 12'o0333, 12'o0000};
        vt[1]  = '{0, 1'b0, DATA_READ,   3'd0, 12'o0200, 12'o0000, 12'o0333};
        vt[2]  = '{0, 1'b1, DATA_READ,   3'd0, 12'o0400, 12'o1111, 12'o0000};
        vt[3]  = '{0, 1'b1, DATA_READ,   3'd3, 12'o0400, 12'o2222, 12'o0000};
        vt[4]  = '{0, 1'b0, DATA_READ,   3'd0, 12'o0400, 12'o0000, 12'o1111};
        vt[5]  = '{1, 1'b0, INSTR_FETCH, 3'd3, 12'o0400, 12'o0000, 12'o2222};
        vt[6]  = '{0, 1'b1, DATA_READ,   3'd0, 12'o0010, 12'o7777, 12'o0000};
        vt[7]  = '{0, 1'b0, AUTO_INDEX,  3'd0, 12'o0010, 12'o0000, 12'o0000};
        vt[8]  = '{0, 1'b0, DATA_READ,   3'd0, 12'o0010, 12'o0000, 12'o0000};
        vt[9]  = '{1, 1'b1, AUTO_INDEX,  3'd0, 12'o0020, 12'o0005, 12'o0000};
        vt[10] = '{0, 1'b0, AUTO_INDEX,  3'd0, 12'o0020, 12'o0000, 12'o0005};
        vt[11] = '{0, 1'b0, DATA_READ,   3'd0, 12'o0020, 12'o0000, 12'o0005};
        vt[12] = '{1, 1'b1, DATA_READ,   3'd7, 12'o0017, 12'o0041, 12'o0000};
        vt[13] = '{1, 1'b0, AUTO_INDEX,  3'd7, 12'o0017, 12'o0000, 12'o0042};
        vt[14] = '{0, 1'b0, INSTR_FETCH, 3'd7, 12'o0017, 12'o0000, 12'o0042};
        vt[15] = '{1, 1'b1, DATA_READ,   3'd7, 12'o7777, 12'o5252, 12'o0000};

        // Reset state
        tick(); tick();
        chk("reset_ack", {30'd0, ack}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rdata", {20'd0, read_data}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            do_txn(vt[i].port, vt[i].w, vt[i].t, vt[i].f, vt[i].a, vt[i].d, 0, 0, rd);
            mdl_apply(vt[i].w, vt[i].t, vt[i].f, vt[i].a, vt[i].d, e);
            chk($sformatf("vec%0d_rdata", i), {20'd0, rd}, {20'd0, vt[i].exp});
        end

        // Both ports requesting continuously: round-robin 0,1,0 with idle gaps
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        req = 2'b11; we = 2'b00;
        read_type = {DATA_READ, DATA_READ};
        field = {3'd3, 3'd0};
        address = {12'o0400, 12'o0200};
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("rr_busy_c%0d", c), {31'd0, busy},
                (c == 4 || c == 8 || c == 12) ? 32'd0 : 32'd1);
            chk($sformatf("rr_ack_c%0d", c), {30'd0, ack},
                (c == 3 || c == 11) ? 32'd1 : (c == 7) ? 32'd2 : 32'd0);
            if (c == 3 || c == 11) chk("rr_rdata_p0", {20'd0, read_data}, {20'd0, 12'o0333});
            if (c == 7)            chk("rr_rdata_p1", {20'd0, read_data}, {20'd0, 12'o2222});
        end
        req = 2'b00;
        tick();

        // Reset during a write access
        do_txn(0, 1'b1, DATA_READ, 3'd0, 12'o0300, 12'o0123, 0, 0, rd);
        mdl_apply(1'b1, DATA_READ, 3'd0, 12'o0300, 12'o0123, e);
        do_txn(0, 1'b0, DATA_READ, 3'd0, 12'o0300, 12'o0000, 0, 0, rd);
        chk("pre_reset_read", {20'd0, rd}, {20'd0, 12'o0123});
        req[0] = 1'b1; we[0] = 1'b1; field[2:0] = 3'd0;
        address[11:0] = 12'o0300; write_data[11:0] = 12'o4444;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("midreset_ack", {30'd0, ack}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_rdata", {20'd0, read_data}, 32'd0);
        req[0] = 1'b0;
        tick();
        chk("midreset_no_ack", {30'd0, ack}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        do_txn(0, 1'b0, DATA_READ, 3'd0, 12'o0300, 12'o0000, 0, 0, rd);
        chk("postreset_old_value", {20'd0, rd}, {20'd0, 12'o0123});

        // Full field-0 sweep: data = address
        for (int a = 0; a < 4096; a++) begin
            do_txn(a % 2, 1'b1, DATA_READ, 3'd0, 12'(a), 12'(a), 0, 0, rd);
            mdl_apply(1'b1, DATA_READ, 3'd0, 12'(a), 12'(a), e);
        end
        for (int a = 0; a < 4096; a++) begin
            do_txn(0, 1'b0, DATA_READ, 3'd0, 12'(a), 12'o0, 0, 0, rd);
            mdl_apply(1'b0, DATA_READ, 3'd0, 12'(a), 12'o0, e);
            chk("sweep_read", {20'd0, rd}, {20'd0, 12'(a)});
        end

        // Randomized traffic against the reference memory
        for (int k = 0; k < 400; k++) begin
            rp = int'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            rt = 2'($urandom_range(0, 2));
            rf = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) tmp_a = 12'(8 + $urandom_range(0, 7));
            else                           tmp_a = 12'($urandom);
            tmp_d = 12'($urandom);
            if (!rw && !mvalid[int'(rf)*4096 + int'(tmp_a)]) rw = 1'b1;
            do_txn(rp, rw, rt, rf, tmp_a, tmp_d,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, rd);
            mdl_apply(rw, rt, rf, tmp_a, tmp_d, e);
            chk($sformatf("rand%0d_f%0d_a%0o", k, rf, tmp_a), {20'd0, rd}, {20'd0, e});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
